// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scan controller.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VBLANK,
    UPDATING
  } upd_state_t;

  localparam int DEF_HPIXEL        = 640;
  localparam int DEF_H_FRONT_PORCH = 16;
  localparam int DEF_H_SYNC_PULSE  = 96;
  localparam int DEF_H_BACK_PORCH  = 48;
  localparam int DEF_VPIXEL        = 480;
  localparam int DEF_V_FRONT_PORCH = 10;
  localparam int DEF_V_SYNC_PULSE  = 2;
  localparam int DEF_V_BACK_PORCH  = 33;

endpackage

// File: rtl/vga_scan_counter.sv
// Horizontal/vertical scan counters with registered frame-start and
// vblank-start strobes, both high in the first clk of the new position.
module vga_scan_counter #(
  parameter logic [11:0] H_TOTAL = 12'd800,
  parameter logic [11:0] V_TOTAL = 12'd525,
  parameter logic [11:0] VPIXEL  = 12'd480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_en,
  output logic [11:0] hcount,
  output logic [11:0] vcount,
  output logic        frame_start,
  output logic        vblank_start
);

  logic h_last;
  logic v_last;

  assign h_last = (hcount == H_TOTAL - 12'd1);
  assign v_last = (vcount == V_TOTAL - 12'd1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount       <= '0;
      vcount       <= '0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      // Strobes mark the tick that lands on (0,0) / (0,VPIXEL); they last
      // one clk even when pixel_en holds the counts for several clks.
      frame_start  <= pixel_en && h_last && v_last;
      vblank_start <= pixel_en && h_last && (vcount == VPIXEL - 12'd1);
      if (pixel_en) begin
        if (h_last) begin
          hcount <= '0;
          vcount <= v_last ? 12'd0 : vcount + 12'd1;
        end else begin
          hcount <= hcount + 12'd1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_scan_controller.sv
// VGA timing generator with a once-per-frame update handshake that fires at
// the start of vertical blanking and flags updates that overrun a frame.
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int HPIXEL        = DEF_HPIXEL,
  parameter int H_FRONT_PORCH = DEF_H_FRONT_PORCH,
  parameter int H_SYNC_PULSE  = DEF_H_SYNC_PULSE,
  parameter int H_BACK_PORCH  = DEF_H_BACK_PORCH,
  parameter int VPIXEL        = DEF_VPIXEL,
  parameter int V_FRONT_PORCH = DEF_V_FRONT_PORCH,
  parameter int V_SYNC_PULSE  = DEF_V_SYNC_PULSE,
  parameter int V_BACK_PORCH  = DEF_V_BACK_PORCH,
  parameter int H_POLARITY    = 0,
  parameter int V_POLARITY    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_en,
  input  logic        run,
  input  logic        upd_done,
  output logic [11:0] hCount,
  output logic [11:0] vCount,
  output logic        hSYNC,
  output logic        vSYNC,
  output logic        video_on,
  output logic        frame_start,
  output logic        upd_start,
  output logic        upd_busy,
  output logic        upd_overrun,
  output logic [15:0] gen_count
);

  localparam logic [11:0] H_TOTAL  = 12'(HPIXEL + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH);
  localparam logic [11:0] V_TOTAL  = 12'(VPIXEL + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH);
  localparam logic [11:0] H_ACTIVE = 12'(HPIXEL);
  localparam logic [11:0] V_ACTIVE = 12'(VPIXEL);
  localparam logic [11:0] H_SYNC_START = 12'(HPIXEL + H_FRONT_PORCH);
  localparam logic [11:0] H_SYNC_END   = 12'(HPIXEL + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [11:0] V_SYNC_START = 12'(VPIXEL + V_FRONT_PORCH);
  localparam logic [11:0] V_SYNC_END   = 12'(VPIXEL + V_FRONT_PORCH + V_SYNC_PULSE);
  localparam logic H_ACT_LVL = (H_POLARITY != 0);
  localparam logic V_ACT_LVL = (V_POLARITY != 0);

  logic       vblank_start;
  upd_state_t state;
  upd_state_t state_next;

  vga_scan_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .VPIXEL  (V_ACTIVE)
  ) u_counter (
    .clk          (clk),
    .rst          (rst),
    .pixel_en     (pixel_en),
    .hcount       (hCount),
    .vcount       (vCount),
    .frame_start  (frame_start),
    .vblank_start (vblank_start)
  );

  assign hSYNC = (hCount >= H_SYNC_START && hCount < H_SYNC_END) ? H_ACT_LVL : ~H_ACT_LVL;
  assign vSYNC = (vCount >= V_SYNC_START && vCount < V_SYNC_END) ? V_ACT_LVL : ~V_ACT_LVL;
  assign video_on = (hCount < H_ACTIVE) && (vCount < V_ACTIVE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    upd_start  = 1'b0;
    case (state)
      IDLE:
        if (run) state_next = WAIT_VBLANK;
      WAIT_VBLANK:
        if (!run) begin
          state_next = IDLE;
        end else if (vblank_start) begin
          state_next = UPDATING;
          upd_start  = 1'b1;
        end
      UPDATING:
        if (upd_done) state_next = IDLE;
      default:
        state_next = IDLE;
    endcase
  end

  assign upd_busy = (state == UPDATING);

  // A completion in the same clk as the frame wrap counts as on time.
  always_ff @(posedge clk) begin
    if (rst) begin
      gen_count   <= '0;
      upd_overrun <= 1'b0;
    end else if (state == UPDATING) begin
      if (upd_done)         gen_count   <= gen_count + 16'd1;
      else if (frame_start) upd_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed self-checking bench for vga_scan_controller using small timing
// (H 8/1/2/1 -> 12 ticks per line, V 4/1/1/1 -> 7 lines per frame).
module tb_vga_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_en;
  logic        run;
  logic        upd_done;
  logic [11:0] hCount;
  logic [11:0] vCount;
  logic        hSYNC;
  logic        vSYNC;
  logic        video_on;
  logic        frame_start;
  logic        upd_start;
  logic        upd_busy;
  logic        upd_overrun;
  logic [15:0] gen_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_scan_controller #(
    .HPIXEL        (8),
    .H_FRONT_PORCH (1),
    .H_SYNC_PULSE  (2),
    .H_BACK_PORCH  (1),
    .VPIXEL        (4),
    .V_FRONT_PORCH (1),
    .V_SYNC_PULSE  (1),
    .V_BACK_PORCH  (1),
    .H_POLARITY    (0),
    .V_POLARITY    (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_en    (pixel_en),
    .run         (run),
    .upd_done    (upd_done),
    .hCount      (hCount),
    .vCount      (vCount),
    .hSYNC       (hSYNC),
    .vSYNC       (vSYNC),
    .video_on    (video_on),
    .frame_start (frame_start),
    .upd_start   (upd_start),
    .upd_busy    (upd_busy),
    .upd_overrun (upd_overrun),
    .gen_count   (gen_count)
  );

  // Leaves the bench at a falling edge with rst just released and counts at (0,0).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; upd_done = 1'b0; pixel_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b1; upd_done = 1'b1; pixel_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (hCount !== 12'd0) begin n_fail++; $display("FAIL reset_hcount got %0d exp 0", hCount); end
      n_checks++; if (vCount !== 12'd0) begin n_fail++; $display("FAIL reset_vcount got %0d exp 0", vCount); end
      n_checks++; if (hSYNC !== 1'b1) begin n_fail++; $display("FAIL reset_hsync got %b exp 1", hSYNC); end
      n_checks++; if (vSYNC !== 1'b1) begin n_fail++; $display("FAIL reset_vsync got %b exp 1", vSYNC); end
      n_checks++; if (video_on !== 1'b1) begin n_fail++; $display("FAIL reset_video_on got %b exp 1", video_on); end
      n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start got %b exp 0", frame_start); end
      n_checks++; if (upd_start !== 1'b0) begin n_fail++; $display("FAIL reset_upd_start got %b exp 0", upd_start); end
      n_checks++; if (upd_busy !== 1'b0) begin n_fail++; $display("FAIL reset_upd_busy got %b exp 0", upd_busy); end
      n_checks++; if (upd_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_upd_overrun got %b exp 0", upd_overrun); end
      n_checks++; if (gen_count !== 16'd0) begin n_fail++; $display("FAIL reset_gen_count got %0d exp 0", gen_count); end
    end
    rst = 1'b0; run = 1'b0; upd_done = 1'b0;
  endtask

  task automatic test_scan();
    int eh, ev;
    do_reset();
    for (int k = 0; k <= 2 * 84 + 2; k++) begin
      eh = k % 12;
      ev = (k / 12) % 7;
      n_checks++; if (hCount !== 12'(eh)) begin n_fail++; $display("FAIL scan_hcount k=%0d got %0d exp %0d", k, hCount, eh); end
      n_checks++; if (vCount !== 12'(ev)) begin n_fail++; $display("FAIL scan_vcount k=%0d got %0d exp %0d", k, vCount, ev); end
      n_checks++; if (hSYNC !== !(eh >= 9 && eh <= 10)) begin n_fail++; $display("FAIL scan_hsync k=%0d got %b", k, hSYNC); end
      n_checks++; if (vSYNC !== !(ev == 5)) begin n_fail++; $display("FAIL scan_vsync k=%0d got %b", k, vSYNC); end
      n_checks++; if (video_on !== (eh < 8 && ev < 4)) begin n_fail++; $display("FAIL scan_video_on k=%0d got %b", k, video_on); end
      n_checks++; if (frame_start !== (k > 0 && k % 84 == 0)) begin n_fail++; $display("FAIL scan_frame_start k=%0d got %b", k, frame_start); end
      @(negedge clk);
    end
  endtask

  task automatic test_tick_gating();
    int ticks;
    do_reset();
    for (int n = 0; n <= 700; n++) begin
      ticks = (n + 3) / 4;
      n_checks++; if (hCount !== 12'(ticks % 12)) begin n_fail++; $display("FAIL gate_hcount n=%0d got %0d exp %0d", n, hCount, ticks % 12); end
      n_checks++; if (vCount !== 12'((ticks / 12) % 7)) begin n_fail++; $display("FAIL gate_vcount n=%0d got %0d exp %0d", n, vCount, (ticks / 12) % 7); end
      n_checks++; if (frame_start !== (n % 4 == 1 && ticks % 84 == 0)) begin n_fail++; $display("FAIL gate_frame_start n=%0d got %b", n, frame_start); end
      pixel_en = (n % 4 == 0);
      @(negedge clk);
    end
    pixel_en = 1'b1;
  endtask

  task automatic test_update();
    do_reset();
    run = 1'b1;
    for (int k = 0; k <= 150; k++) begin
      n_checks++; if (upd_start !== (k == 48 || k == 132)) begin n_fail++; $display("FAIL upd_start k=%0d got %b", k, upd_start); end
      n_checks++; if (upd_busy !== ((k >= 49 && k <= 53) || (k >= 133 && k <= 137))) begin n_fail++; $display("FAIL upd_busy k=%0d got %b", k, upd_busy); end
      n_checks++; if (gen_count !== ((k >= 138) ? 16'd2 : (k >= 54) ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL upd_gen_count k=%0d got %0d", k, gen_count); end
      n_checks++; if (upd_overrun !== 1'b0) begin n_fail++; $display("FAIL upd_overrun k=%0d got %b exp 0", k, upd_overrun); end
      // k=20 and k=100 are stray completions while not updating.
      upd_done = (k == 20 || k == 53 || k == 100 || k == 137);
      @(negedge clk);
    end
    upd_done = 1'b0; run = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    run = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      n_checks++; if (upd_overrun !== (k >= 85)) begin n_fail++; $display("FAIL ovr_overrun k=%0d got %b", k, upd_overrun); end
      n_checks++; if (upd_busy !== (k >= 49 && k <= 90)) begin n_fail++; $display("FAIL ovr_busy k=%0d got %b", k, upd_busy); end
      n_checks++; if (gen_count !== ((k >= 91) ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL ovr_gen_count k=%0d got %0d", k, gen_count); end
      run      = (k < 60);
      upd_done = (k == 90);
      @(negedge clk);
    end
    upd_done = 1'b0; run = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    run = 1'b1;
    for (int k = 0; k <= 90; k++) begin
      n_checks++; if (upd_overrun !== 1'b0) begin n_fail++; $display("FAIL sim_overrun k=%0d got %b exp 0", k, upd_overrun); end
      n_checks++; if (upd_busy !== (k >= 49 && k <= 84)) begin n_fail++; $display("FAIL sim_busy k=%0d got %b", k, upd_busy); end
      n_checks++; if (gen_count !== ((k >= 85) ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL sim_gen_count k=%0d got %0d", k, gen_count); end
      upd_done = (k == 84);
      @(negedge clk);
    end
    upd_done = 1'b0; run = 1'b0;
  endtask

  task automatic test_reset_mid_update();
    do_reset();
    run = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      if (k == 59) begin
        n_checks++; if (upd_busy !== 1'b1) begin n_fail++; $display("FAIL rmu_busy_before got %b exp 1", upd_busy); end
      end
      if (k == 61) begin
        n_checks++; if (hCount !== 12'd0) begin n_fail++; $display("FAIL rmu_hcount got %0d exp 0", hCount); end
        n_checks++; if (vCount !== 12'd0) begin n_fail++; $display("FAIL rmu_vcount got %0d exp 0", vCount); end
        n_checks++; if (hSYNC !== 1'b1 || vSYNC !== 1'b1) begin n_fail++; $display("FAIL rmu_sync got h=%b v=%b exp 1 1", hSYNC, vSYNC); end
        n_checks++; if (video_on !== 1'b1) begin n_fail++; $display("FAIL rmu_video_on got %b exp 1", video_on); end
        n_checks++; if (frame_start !== 1'b0 || upd_start !== 1'b0) begin n_fail++; $display("FAIL rmu_pulses got fs=%b us=%b exp 0 0", frame_start, upd_start); end
        n_checks++; if (upd_overrun !== 1'b0) begin n_fail++; $display("FAIL rmu_overrun got %b exp 0", upd_overrun); end
      end
      if (k >= 61) begin
        n_checks++; if (upd_busy !== 1'b0) begin n_fail++; $display("FAIL rmu_busy k=%0d got %b exp 0", k, upd_busy); end
        n_checks++; if (gen_count !== 16'd0) begin n_fail++; $display("FAIL rmu_gen_count k=%0d got %0d exp 0", k, gen_count); end
      end
      rst      = (k == 60);
      if (k == 60) run = 1'b0;
      upd_done = (k == 61);
      @(negedge clk);
    end
    upd_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pixel_en = 1'b1; run = 1'b0; upd_done = 1'b0;
    test_reset();
    test_scan();
    test_tick_gating();
    test_update();
    test_overrun();
    test_simultaneous();
    test_reset_mid_update();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scan_controller.md
VGA_SCAN_CONTROLLER -- requirements
Module: vga_scan_controller

Interface
REQ-001 Param HPIXEL, default 640, active pixels per line.
REQ-002 Params H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH, defaults 16, 96, 48, horizontal blanking segments in pixel ticks.
REQ-003 Param VPIXEL, default 480, active lines per frame.
REQ-004 Params V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH, defaults 10, 2, 33, vertical blanking segments in lines.
REQ-005 Params H_POLARITY and V_POLARITY, default 0 each; 0 means the sync is low during the pulse, 1 means it is high.
REQ-006 Ports: clk in 1, system clock; one clock; all logic on rising edge.
REQ-007 Ports: rst in 1, synchronous, active-high reset.
REQ-008 Ports: pixel_en in 1, pixel tick; counters advance only when high.
REQ-009 Ports: run in 1, enables per-frame update requests.
REQ-010 Ports: upd_done in 1, one-clk pulse from the update engine when a generation finishes.
REQ-011 Ports: hCount and vCount out 12 each, current scan position.
REQ-012 Ports: hSYNC and vSYNC out 1 each; video_on out 1, which is high in the active area.
REQ-013 Ports: frame_start out 1, upd_start out 1, upd_busy out 1, upd_overrun out 1.
REQ-014 Ports: gen_count out 16, completed generations.

Function
REQ-015 H_TOTAL = sum of the four H params; V_TOTAL = sum of the four V params; all compares are done at 12 bits.
REQ-016 On pixel_en, hCount increments; when hCount = H_TOTAL-1, hCount wraps to 0 and vCount increments.
REQ-017 When vCount = V_TOTAL-1 and hCount wraps, vCount also wraps to 0.
REQ-018 When pixel_en is low, all counters hold.
REQ-019 hSYNC is active when HPIXEL+H_FRONT_PORCH <= hCount < HPIXEL+H_FRONT_PORCH+H_SYNC_PULSE; the output level follows H_POLARITY.
REQ-020 vSYNC uses the same rule on vCount with the V params and V_POLARITY.
REQ-021 hSYNC, vSYNC and video_on are decoded from the registered counts, with zero added latency.
REQ-022 video_on = (hCount < HPIXEL) && (vCount < VPIXEL).
REQ-023 frame_start is a registered one-clk pulse, high in the first clk in which the counts read (0,0) after a wrap; it is not asserted out of reset.
REQ-024 The update FSM has three states: IDLE, WAIT_VBLANK and UPDATING.
REQ-025 IDLE goes to WAIT_VBLANK when run=1.
REQ-026 WAIT_VBLANK goes to IDLE when run=0.
REQ-027 WAIT_VBLANK goes to UPDATING in the first clk the counts read (hCount=0, vCount=VPIXEL); upd_start pulses for that one clk.
REQ-028 UPDATING goes to IDLE on upd_done, and gen_count increments, wrapping at 16 bits.
REQ-029 IDLE re-arms on the next clk if run is still 1.
REQ-030 upd_busy = (state == UPDATING).
REQ-031 upd_done in IDLE or WAIT_VBLANK is ignored.
REQ-032 run falling during UPDATING does not abort the update; the FSM finishes, then goes to IDLE.
REQ-033 If the counts wrap to (0,0) while in UPDATING, upd_overrun is set sticky and the state stays UPDATING.
REQ-034 If upd_done and the (0,0) wrap occur in the same clk, upd_done wins and upd_overrun is not set.
REQ-035 At most one upd_start is issued per frame, even if run toggles.

Reset
REQ-036 rst sets hCount=0, vCount=0 and the FSM to IDLE.
REQ-037 rst clears frame_start, upd_start, upd_busy, upd_overrun and gen_count.
REQ-038 During reset, hSYNC and vSYNC sit at their inactive levels (1 for polarity 0) and video_on=1, as decoded from (0,0).
REQ-039 rst mid-UPDATING discards the update; upd_done arriving after reset is ignored.
REQ-040 upd_overrun is cleared only by rst.

Structure
REQ-041 Package vga_pkg holds the FSM state enum and the 640x480 default timing constants.
REQ-042 Sub-module vga_scan_counter holds the h/v counters, the wrap logic and frame_start.
REQ-043 The FSM and sync decode live in the top level.

Verification
All scenarios use small params: H 8/1/2/1 (H_TOTAL 12), V 4/1/1/1 (V_TOTAL 7), polarity 0, pixel_en always 1 unless stated.
REQ-044 Scan check: after rst, hSYNC low exactly for hCount 9..10; vSYNC low exactly for vCount 5; video_on high for h<8, v<4; frame_start period 84 clks.
REQ-045 Tick gating: pixel_en=1 only every 4th clk -> counts advance once per 4 clks; frame_start period 336 clks.
REQ-046 Update handshake: run=1 at frame start -> upd_start once at (0,4); upd_done 5 clks later -> gen_count=1, upd_busy low; next upd_start at (0,4) of the next frame.
REQ-047 Overrun: withhold upd_done past the wrap to (0,0) -> upd_overrun=1 and upd_busy=1; a later upd_done -> IDLE, upd_overrun stays 1.
REQ-048 Simultaneous events: upd_done in the same clk as the wrap to (0,0) -> upd_overrun=0.
REQ-049 Reset mid-update: rst during UPDATING -> next clk all outputs at reset values; a subsequent upd_done leaves gen_count=0.
